// File: rtl/nibble_serial_alu_seq.sv
// ============================================================================
// Module   : nibble_serial_alu_seq
// Purpose  : Drives one external 74181 slice nibble-by-nibble (LSB first),
//            rippling carry through a flop and assembling the wide result.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module nibble_serial_alu_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic [3:0]           op_s,
    input  logic                 op_m,
    input  logic                 cin,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [3:0]           alu_s,
    output logic                 alu_m,
    output logic                 alu_cnb,
    input  logic [3:0]           alu_f,
    input  logic                 alu_cn4b,
    input  logic                 alu_aeb,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 zero,
    output logic                 eq
);

    localparam int c_width = 4 * NIBBLES;
    localparam int c_idx_w = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_width-1:0]   r_a;
    logic [c_width-1:0]   r_b;
    logic [3:0]           r_s;
    logic                 r_m;
    logic                 r_carry;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_eq_acc;
    logic [c_width-1:0]   r_result;
    logic                 r_cout;
    logic                 r_zero;
    logic                 r_eq;

    logic [3:0]           w_nib_a;
    logic [3:0]           w_nib_b;
    logic [c_width-1:0]   w_result_next;
    logic                 w_carry_next;
    logic                 w_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN:  if (r_idx == c_last_idx) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Select the active operand nibbles and merge the slice output into the result
    always_comb begin
        w_nib_a       = '0;
        w_nib_b       = '0;
        w_result_next = r_result;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_nib_a                  = r_a[4*i +: 4];
                w_nib_b                  = r_b[4*i +: 4];
                w_result_next[4*i +: 4]  = alu_f;
            end
        end
    end

    assign w_carry_next = r_m ? 1'b0 : ~alu_cn4b;
    assign w_run        = (r_state == ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_s      <= '0;
            r_m      <= 1'b0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_eq_acc <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b0;
            r_eq     <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_a      <= op_a;
            r_b      <= op_b;
            r_s      <= op_s;
            r_m      <= op_m;
            // Logic mode never sees a carry into the first nibble
            r_carry  <= cin & ~op_m;
            r_idx    <= '0;
            r_eq_acc <= 1'b1;
        end else if (w_run) begin
            r_result <= w_result_next;
            r_carry  <= w_carry_next;
            r_eq_acc <= r_eq_acc & alu_aeb;
            if (r_idx == c_last_idx) begin
                r_cout <= w_carry_next;
                r_zero <= (w_result_next == '0);
                r_eq   <= r_eq_acc & alu_aeb;
            end else begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

    assign alu_a   = w_run ? w_nib_a : 4'h0;
    assign alu_b   = w_run ? w_nib_b : 4'h0;
    assign alu_s   = w_run ? r_s : 4'h0;
    assign alu_m   = w_run & r_m;
    assign alu_cnb = w_run ? ~r_carry : 1'b1;
    assign busy    = w_run;
    assign done    = (r_state == ST_DONE);
    assign result  = r_result;
    assign cout    = r_cout;
    assign zero    = r_zero;
    assign eq      = r_eq;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_alu_seq.sv
// ============================================================================
// Module   : tb_nibble_serial_alu_seq
// Purpose  : Table-driven bench for nibble_serial_alu_seq with a 74181 model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_nibble_serial_alu_seq;

    localparam int NIBBLES = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  op_s;
    logic        op_m;
    logic        cin;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [3:0]  alu_s;
    logic        alu_m;
    logic        alu_cnb;
    logic [3:0]  alu_f;
    logic        alu_cn4b;
    logic        alu_aeb;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic        zero;
    logic        eq;

    int checks = 0;
    int errors = 0;

    nibble_serial_alu_seq #(.NIBBLES(NIBBLES)) dut (
        .clk(clk), .rst(rst), .start(start),
        .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .cin(cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m),
        .alu_cnb(alu_cnb), .alu_f(alu_f), .alu_cn4b(alu_cn4b), .alu_aeb(alu_aeb),
        .busy(busy), .done(done), .result(result), .cout(cout),
        .zero(zero), .eq(eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-high-data 74181: returns {aeb, cn4b, f}
    function automatic logic [5:0] f181(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] s, input logic m,
                                        input logic cnb);
        logic       c;
        logic       p;
        logic       g;
        logic [3:0] f;
        c = ~cnb;
        f = 4'h0;
        for (int i = 0; i < 4; i++) begin
            p    = a[i] | (b[i] & s[0]) | (~b[i] & s[1]);
            g    = (a[i] & ~b[i] & s[2]) | (a[i] & b[i] & s[3]);
            f[i] = m ? ~(p & ~g) : ((p & ~g) ^ c);
            c    = g | (p & c);
        end
        return {(f == 4'hF), ~c, f};
    endfunction

    always_comb {alu_aeb, alu_cn4b, alu_f} = f181(alu_a, alu_b, alu_s, alu_m, alu_cnb);

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  s;
        logic        m;
        logic        cin;
        logic [15:0] res;
        logic        cout;
        logic        zero;
        logic        eq;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int          busy_n;
        int          done_n;
        int          done_k;
        int          nib_bad;
        int          cnb_bad;
        logic [15:0] ta;
        logic [15:0] tb;
        op_a  = v.a;
        op_b  = v.b;
        op_s  = v.s;
        op_m  = v.m;
        cin   = v.cin;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble inputs: the operation must use only latched values
        op_a = ~v.a;
        op_b = ~v.b;
        op_s = ~v.s;
        op_m = ~v.m;
        cin  = ~v.cin;
        busy_n = 0; done_n = 0; done_k = 0; nib_bad = 0; cnb_bad = 0;
        for (int k = 1; k <= 8; k++) begin
            if (busy) begin
                busy_n++;
                if (k <= NIBBLES) begin
                    ta = v.a >> (4 * (k - 1));
                    tb = v.b >> (4 * (k - 1));
                    if (alu_a !== ta[3:0] || alu_b !== tb[3:0] ||
                        alu_s !== v.s || alu_m !== v.m)
                        nib_bad++;
                end
                if (v.m && alu_cnb !== 1'b1) cnb_bad++;
            end
            if (done) begin
                done_n++;
                if (done_k == 0) done_k = k;
            end
            if (k == 2) start = 1'b1;
            if (k == 3) start = 1'b0;
            @(posedge clk); #1;
        end
        chk($sformatf("v%0d done_cycle", n), 32'(done_k), 32'd5);
        chk($sformatf("v%0d done_pulses", n), 32'(done_n), 32'd1);
        chk($sformatf("v%0d busy_cycles", n), 32'(busy_n), 32'd4);
        chk($sformatf("v%0d slice_drive_errs", n), 32'(nib_bad), 32'd0);
        chk($sformatf("v%0d cnb_logic_errs", n), 32'(cnb_bad), 32'd0);
        chk($sformatf("v%0d result", n), 32'(result), 32'(v.res));
        chk($sformatf("v%0d cout", n), 32'(cout), 32'(v.cout));
        chk($sformatf("v%0d zero", n), 32'(zero), 32'(v.zero));
        chk($sformatf("v%0d eq", n), 32'(eq), 32'(v.eq));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " result"}, 32'(result), 32'd0);
        chk({tag, " cout"}, 32'(cout), 32'd0);
        chk({tag, " zero"}, 32'(zero), 32'd0);
        chk({tag, " eq"}, 32'(eq), 32'd0);
        chk({tag, " alu_a"}, 32'(alu_a), 32'd0);
        chk({tag, " alu_b"}, 32'(alu_b), 32'd0);
        chk({tag, " alu_s"}, 32'(alu_s), 32'd0);
        chk({tag, " alu_m"}, 32'(alu_m), 32'd0);
        chk({tag, " alu_cnb"}, 32'(alu_cnb), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_seen;
        //          a         b         s        m     cin   res       cout  zero  eq
        vecs[0] = '{16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{16'h0F3C, 16'h33FF, 4'b1011, 1'b1, 1'b1, 16'h033C, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'h1000, 16'h0001, 4'b0110, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{16'hFFFF, 16'h1234, 4'b0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'h8421, 16'h0000, 4'b0000, 1'b0, 1'b0, 16'h8421, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'h0000, 16'hABCD, 4'b0000, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0;
        op_a = '0; op_b = '0; op_s = '0; op_m = 1'b0; cin = 1'b0;
        #3;
        chk_reset_state("por");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle busy", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Abort in the second RUN cycle; result currently holds 16'hFFFF
        op_a = 16'h1234; op_b = 16'h0FFF; op_s = 4'b1001; op_m = 1'b0; cin = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("abort pre busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_state("abort");
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        chk("abort no_done", 32'(done_seen), 32'd0);
        chk("abort result_held", 32'(result), 32'd0);

        run_vec(8, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
